mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 97 +++++++++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage:
// op codes, widths, FSM encoding and lane helpers.
package mem_stage_pkg;

  localparam int REG_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] NOPREGADDR = '0;
  localparam logic [REG_W-1:0] ZEROWORD = '0;
  localparam logic STOP = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

  function automatic mem_size_e op_size(
    input logic [7:0] op
  );
    mem_size_e s;
    unique case (1'b1)
      op == EXE_LB_OP,
      op == EXE_LBU_OP,
      op == EXE_SB_OP: s = SZ_B;
      op == EXE_LH_OP,
      op == EXE_LHU_OP,
      op == EXE_SH_OP: s = SZ_H;
      op == EXE_LW_OP,
      op == EXE_SW_OP: s = SZ_W;
      default:         s = SZ_NONE;
    endcase
    return s;
  endfunction

  function automatic logic op_store(
    input logic [7:0] op
  );
    return (op == EXE_SB_OP) ||
           (op == EXE_SH_OP) ||
           (op == EXE_SW_OP);
  endfunction

  function automatic logic misaligned(
    input mem_size_e sz,
    input logic [1:0] off
  );
    return ((sz == SZ_H) && off[0]) ||
           ((sz == SZ_W) && (off != 2'b00));
  endfunction

  // Big-endian lanes: byte 0 lives in sel[3].
  function automatic logic [3:0] lane_sel(
    input mem_size_e sz,
    input logic [1:0] off
  );
    logic [3:0] s;
    unique case (sz)
      SZ_B:    s = 4'b1000 >> off;
      SZ_H:    s = off[1] ? 4'b0011 : 4'b1100;
      SZ_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [REG_W-1:0] store_data(
    input mem_size_e sz,
    input logic [REG_W-1:0] reg2
  );
    logic [REG_W-1:0] d;
    unique case (sz)
      SZ_B:    d = {4{reg2[7:0]}};
      SZ_H:    d = {2{reg2[15:0]}};
      default: d = reg2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed lane of a bus read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]       aluop,
  input  logic [1:0]       addr,
  input  logic [REG_W-1:0] rdata,
  output logic [REG_W-1:0] word
);

  logic [7:0] b;
  logic [15:0] h;

  always_comb begin
    unique case (addr)
      2'b00:   b = rdata[31:24];
      2'b01:   b = rdata[23:16];
      2'b10:   b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = addr[1] ? rdata[15:0] : rdata[31:16];
    unique case (1'b1)
      aluop == EXE_LB_OP:  word = {{24{b[7]}}, b};
      aluop == EXE_LBU_OP: word = {24'h0, b};
      aluop == EXE_LH_OP:  word = {{16{h[15]}}, h};
      aluop == EXE_LHU_OP: word = {16'h0, h};
      default:             word = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data bus for loads and
// stores and stalls the pipeline until the bus acks.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [REG_W-1:0]  ex_wdata,
  input  logic [REG_W-1:0]  ex_hi,
  input  logic [REG_W-1:0]  ex_lo,
  input  logic              ex_whilo,
  input  logic [7:0]        ex_aluop,
  input  logic [REG_W-1:0]  ex_mem_addr,
  input  logic [REG_W-1:0]  ex_reg2,
  input  logic [5:0]        stall,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [REG_W-1:0]  mem_wdata,
  output logic [REG_W-1:0]  mem_hi,
  output logic [REG_W-1:0]  mem_lo,
  output logic              mem_whilo,
  output logic              stallreq_mem,
  output logic              misalign,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [REG_W-1:0]  dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [REG_W-1:0]  dbus_wdata,
  input  logic              dbus_ack,
  input  logic [REG_W-1:0]  dbus_rdata
);

  mem_state_e state;
  mem_size_e sz;
  logic mem_op;
  logic bad;
  logic start;
  logic [REG_W-1:0] word_addr;

  logic [7:0] r_op;
  logic [1:0] r_off;
  logic [REG_W-1:0] r_addr;
  logic [3:0] r_sel;
  logic [REG_W-1:0] r_wdata;
  logic [REG_W-1:0] lbuf;
  logic [REG_W-1:0] load_word;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign sz = op_size(ex_aluop);
  assign mem_op = (sz != SZ_NONE);
  assign bad = mem_op && misaligned(sz, ex_mem_addr[1:0]);
  assign start = (state == ST_IDLE) && mem_op && !bad;
  assign word_addr = {ex_mem_addr[31:2], 2'b00};

  mem_load_align u_align (
    .aluop (r_op),
    .addr  (r_off),
    .rdata (dbus_rdata),
    .word  (load_word)
  );

  // Request fields are latched at start so they hold until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lbuf <= ZEROWORD;
      r_op <= 8'h00;
      r_off <= 2'b00;
      r_addr <= ZEROWORD;
      r_sel <= 4'b0000;
      r_wdata <= ZEROWORD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_WAIT;
            r_op <= ex_aluop;
            r_off <= ex_mem_addr[1:0];
            r_addr <= word_addr;
            r_sel <= lane_sel(sz, ex_mem_addr[1:0]);
            r_wdata <= store_data(sz, ex_reg2);
          end
        end
        ST_WAIT: begin
          if (dbus_ack) begin
            state <= ST_DONE;
            if (!op_store(r_op)) lbuf <= load_word;
          end
        end
        ST_DONE: begin
          if (!stall[4]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wd = ex_wd;
    mem_wreg = ex_wreg;
    mem_wdata = ex_wdata;
    mem_hi = ex_hi;
    mem_lo = ex_lo;
    mem_whilo = ex_whilo;
    stallreq_mem = NOSTOP;
    misalign = 1'b0;
    dbus_req = 1'b0;
    dbus_we = 1'b0;
    dbus_addr = ZEROWORD;
    dbus_sel = 4'b0000;
    dbus_wdata = ZEROWORD;
    if (rst) begin
      mem_wd = NOPREGADDR;
      mem_wreg = 1'b0;
      mem_wdata = ZEROWORD;
      mem_hi = ZEROWORD;
      mem_lo = ZEROWORD;
      mem_whilo = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bad) begin
            misalign = 1'b1;
            mem_wreg = 1'b0;
          end else if (mem_op) begin
            dbus_req = 1'b1;
            stallreq_mem = STOP;
            mem_wreg = 1'b0;
            dbus_we = op_store(ex_aluop);
            dbus_addr = word_addr;
            dbus_sel = lane_sel(sz, ex_mem_addr[1:0]);
            dbus_wdata = store_data(sz, ex_reg2);
          end
        end
        ST_WAIT: begin
          dbus_req = 1'b1;
          stallreq_mem = STOP;
          mem_wreg = 1'b0;
          dbus_we = op_store(r_op);
          dbus_addr = r_addr;
          dbus_sel = r_sel;
          dbus_wdata = r_wdata;
        end
        ST_DONE: begin
          if (!op_store(r_op)) mem_wdata = lbuf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores,
// misalignment, reset mid-access and DONE hold.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ex_wd;
  logic ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic ex_whilo;
  logic [7:0] ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [5:0] stall;
  logic [4:0] mem_wd;
  logic mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic mem_whilo;
  logic stallreq_mem;
  logic misalign;
  logic dbus_req;
  logic dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0] dbus_sel;
  logic [31:0] dbus_wdata;
  logic dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .stall        (stall),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .stallreq_mem (stallreq_mem),
    .misalign     (misalign),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_sel     (dbus_sel),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    ex_aluop = 8'h00;
    ex_wd = 5'd0;
    ex_wreg = 1'b0;
    ex_wdata = 32'h0;
    ex_hi = 32'h0;
    ex_lo = 32'h0;
    ex_whilo = 1'b0;
    ex_mem_addr = 32'h0;
    ex_reg2 = 32'h0;
  endtask

  // Runs one aligned access; returns at the DONE-cycle negedge.
  task automatic access(
    input string tag,
    input logic [7:0] op,
    input logic [31:0] addr,
    input logic [31:0] reg2,
    input logic wreg,
    input int nwait,
    input logic [31:0] rdata,
    input logic [3:0] exp_sel,
    output logic we,
    output logic [31:0] bw,
    output logic [31:0] res,
    output logic res_wreg,
    output int nst
  );
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    nop();
    ex_aluop = op;
    ex_mem_addr = addr;
    ex_reg2 = reg2;
    ex_wreg = wreg;
    ex_wd = 5'd9;
    ex_wdata = 32'h5a5a0000;
    nst = 0;
    @(negedge clk);
    check({tag, "_req"}, 32'(dbus_req), 32'd1);
    check({tag, "_sel"}, 32'(dbus_sel), 32'(exp_sel));
    check({tag, "_addr"}, dbus_addr, waddr);
    check({tag, "_wreg0"}, 32'(mem_wreg), 32'd0);
    we = dbus_we;
    bw = dbus_wdata;
    if (stallreq_mem) nst++;
    for (int i = 1; i <= nwait; i++) begin
      step();
      if (i == nwait) begin
        dbus_ack = 1'b1;
        dbus_rdata = rdata;
      end
      @(negedge clk);
      if (stallreq_mem) nst++;
      check({tag, "_hold_sel"}, 32'(dbus_sel), 32'(exp_sel));
      check({tag, "_hold_addr"}, dbus_addr, waddr);
    end
    step();
    dbus_ack = 1'b0;
    dbus_rdata = 32'hdeadbeef;
    @(negedge clk);
    res = mem_wdata;
    res_wreg = mem_wreg;
    if (stallreq_mem) nst++;
  endtask

  logic we;
  logic rwreg;
  logic [31:0] bw;
  logic [31:0] res;
  int nst;

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    ex_aluop = EXE_LW_OP;
    ex_mem_addr = 32'h100;
    ex_wd = 5'h1f;
    ex_wreg = 1'b1;
    ex_wdata = 32'hdeadbeef;
    ex_hi = 32'h1;
    ex_lo = 32'h2;
    ex_whilo = 1'b1;
    ex_reg2 = 32'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_stall", 32'(stallreq_mem), 32'd0);
    check("rst_wreg", 32'(mem_wreg), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wd", 32'(mem_wd), 32'd0);
    check("rst_whilo", 32'(mem_whilo), 32'd0);
    check("rst_hi", mem_hi, 32'h0);
    check("rst_addr", dbus_addr, 32'h0);

    step();
    rst = 1'b0;
    nop();
    ex_aluop = 8'h21;
    ex_wd = 5'd3;
    ex_wreg = 1'b1;
    ex_wdata = 32'h12345678;
    ex_hi = 32'h11112222;
    ex_lo = 32'h33334444;
    ex_whilo = 1'b1;
    #1;
    check("pass_wdata", mem_wdata, 32'h12345678);
    check("pass_wd", 32'(mem_wd), 32'd3);
    check("pass_wreg", 32'(mem_wreg), 32'd1);
    check("pass_hi", mem_hi, 32'h11112222);
    check("pass_lo", mem_lo, 32'h33334444);
    check("pass_whilo", 32'(mem_whilo), 32'd1);
    check("pass_stall", 32'(stallreq_mem), 32'd0);
    check("pass_req", 32'(dbus_req), 32'd0);

    step();
    access("lw", EXE_LW_OP, 32'h100, 32'h0, 1'b1, 3,
           32'hCAFEBABE, 4'b1111, we, bw, res, rwreg, nst);
    check("lw_we", 32'(we), 32'd0);
    check("lw_data", res, 32'hCAFEBABE);
    check("lw_wreg", 32'(rwreg), 32'd1);
    check("lw_stall_cycles", nst, 4);
    step();
    nop();
    #1;
    check("lw_after_wreg", 32'(mem_wreg), 32'd0);

    step();
    access("lb", EXE_LB_OP, 32'h103, 32'h0, 1'b1, 1,
           32'h123456F0, 4'b0001, we, bw, res, rwreg, nst);
    check("lb_data", res, 32'hFFFFFFF0);
    step();
    access("lbu", EXE_LBU_OP, 32'h103, 32'h0, 1'b1, 1,
           32'h123456F0, 4'b0001, we, bw, res, rwreg, nst);
    check("lbu_data", res, 32'h000000F0);
    step();
    access("lh", EXE_LH_OP, 32'h102, 32'h0, 1'b1, 1,
           32'h12348001, 4'b0011, we, bw, res, rwreg, nst);
    check("lh_data", res, 32'hFFFF8001);
    step();
    access("lhu", EXE_LHU_OP, 32'h100, 32'h0, 1'b1, 2,
           32'h87650000, 4'b1100, we, bw, res, rwreg, nst);
    check("lhu_data", res, 32'h00008765);
    step();
    access("lb0", EXE_LB_OP, 32'h100, 32'h0, 1'b1, 1,
           32'h7F000000, 4'b1000, we, bw, res, rwreg, nst);
    check("lb0_data", res, 32'h0000007F);

    step();
    access("sh", EXE_SH_OP, 32'h202, 32'hAAAABEEF, 1'b0, 2,
           32'h0, 4'b0011, we, bw, res, rwreg, nst);
    check("sh_we", 32'(we), 32'd1);
    check("sh_wdata", bw, 32'hBEEFBEEF);
    check("sh_wreg", 32'(rwreg), 32'd0);
    check("sh_res", res, 32'h5a5a0000);
    step();
    access("sb", EXE_SB_OP, 32'h201, 32'h12345678, 1'b0, 1,
           32'h0, 4'b0100, we, bw, res, rwreg, nst);
    check("sb_we", 32'(we), 32'd1);
    check("sb_wdata", bw, 32'h78787878);
    step();
    access("sw", EXE_SW_OP, 32'h204, 32'h01020304, 1'b0, 1,
           32'h0, 4'b1111, we, bw, res, rwreg, nst);
    check("sw_wdata", bw, 32'h01020304);

    step();
    nop();
    ex_aluop = EXE_LW_OP;
    ex_mem_addr = 32'h101;
    ex_wreg = 1'b1;
    ex_wd = 5'd4;
    @(negedge clk);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_req", 32'(dbus_req), 32'd0);
    check("mis_stall", 32'(stallreq_mem), 32'd0);
    check("mis_wreg", 32'(mem_wreg), 32'd0);
    step();
    nop();
    @(negedge clk);
    check("mis_clear", 32'(misalign), 32'd0);
    step();
    ex_aluop = EXE_LH_OP;
    ex_mem_addr = 32'h203;
    @(negedge clk);
    check("mis_lh", 32'(misalign), 32'd1);
    check("mis_lh_req", 32'(dbus_req), 32'd0);

    step();
    nop();
    ex_aluop = EXE_LW_OP;
    ex_mem_addr = 32'h300;
    ex_wreg = 1'b1;
    ex_wd = 5'd6;
    ex_wdata = 32'h300;
    @(negedge clk);
    check("rw_req", 32'(dbus_req), 32'd1);
    step();
    @(negedge clk);
    check("rw_wait_stall", 32'(stallreq_mem), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_req", 32'(dbus_req), 32'd0);
    check("rw_rst_stall", 32'(stallreq_mem), 32'd0);
    check("rw_rst_wdata", mem_wdata, 32'h0);
    check("rw_rst_sel", 32'(dbus_sel), 32'd0);
    step();
    rst = 1'b0;
    nop();
    @(negedge clk);
    check("rw_idle_req", 32'(dbus_req), 32'd0);
    check("rw_idle_stall", 32'(stallreq_mem), 32'd0);
    step();
    dbus_ack = 1'b1;
    dbus_rdata = 32'h77777777;
    @(negedge clk);
    check("rw_ack_stall", 32'(stallreq_mem), 32'd0);
    check("rw_ack_wdata", mem_wdata, 32'h0);
    step();
    dbus_ack = 1'b0;
    @(negedge clk);
    check("rw_late_wdata", mem_wdata, 32'h0);
    check("rw_late_wreg", 32'(mem_wreg), 32'd0);
    step();
    access("post_rst", EXE_LW_OP, 32'h400, 32'h0, 1'b1, 1,
           32'h44444444, 4'b1111, we, bw, res, rwreg, nst);
    check("post_rst_data", res, 32'h44444444);
    check("post_rst_stall_cycles", nst, 2);

    step();
    stall = 6'b010000;
    access("stl", EXE_LW_OP, 32'h500, 32'h0, 1'b1, 1,
           32'h0BADF00D, 4'b1111, we, bw, res, rwreg, nst);
    check("stl_data", res, 32'h0BADF00D);
    check("stl_wreg", 32'(rwreg), 32'd1);
    step();
    @(negedge clk);
    check("stl_hold_data", mem_wdata, 32'h0BADF00D);
    check("stl_hold_wreg", 32'(mem_wreg), 32'd1);
    check("stl_hold_stall", 32'(stallreq_mem), 32'd0);
    check("stl_hold_req", 32'(dbus_req), 32'd0);
    step();
    stall = 6'b0;
    @(negedge clk);
    check("stl_last_data", mem_wdata, 32'h0BADF00D);
    step();
    access("after_stl", EXE_LW_OP, 32'h504, 32'h0, 1'b1, 1,
           32'h00000005, 4'b1111, we, bw, res, rwreg, nst);
    check("after_stl_data", res, 32'h00000005);

    step();
    nop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
